// File: rtl/id_operand_buffer_if.sv
// Handshake bundle for the decode-stage operand buffer: upstream push channel and
// downstream head channel. Signal suffixes are from the buffer's point of view.
interface id_operand_buffer_if #(
  parameter int WIDTH     = 34,
  parameter int NUM_LANES = 2
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [NUM_LANES-1:0] in_mask_i;
  logic [WIDTH-1:0]     in_data_i [NUM_LANES];
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [NUM_LANES-1:0] out_mask_o;
  logic [WIDTH-1:0]     out_data_o [NUM_LANES];

  modport slave (
    input  in_valid_i, in_mask_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_mask_o, out_data_o
  );

  modport master (
    output in_valid_i, in_mask_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_mask_o, out_data_o
  );
endinterface

// File: rtl/id_operand_buffer.sv
// Circular FIFO of operand bundles with per-lane masking on the head output.
// Define OPBUF_BYPASS_EN for a combinational empty-buffer pass-through path.
module id_operand_buffer #(
  parameter  int WIDTH     = 34,
  parameter  int NUM_LANES = 2,
  parameter  int DEPTH     = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  id_operand_buffer_if.slave        bus,
  output logic [CW-1:0]             count_o
);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [NUM_LANES-1:0] mask_mem [DEPTH];
  logic [WIDTH-1:0]     data_mem [DEPTH][NUM_LANES];

  logic                 empty, full, pop, push, write;
  logic                 head_valid;
  logic [NUM_LANES-1:0] head_mask;
  logic [WIDTH-1:0]     head_data [NUM_LANES];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = ~empty & bus.out_ready_i;
  assign push  = bus.in_valid_i & bus.in_ready_o;

  assign bus.in_ready_o = ~full | pop;

`ifdef OPBUF_BYPASS_EN
  logic bypass_show;
  assign bypass_show = empty & bus.in_valid_i & ~flush_i;
  // A bypassed bundle consumed downstream this cycle must not also be stored.
  assign write = push & ~(bypass_show & bus.out_ready_i);
`else
  assign write = push;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (write) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({write, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (write && !flush_i) begin
      mask_mem[wr_ptr_q] <= bus.in_mask_i;
      for (int k = 0; k < NUM_LANES; k++) begin
        data_mem[wr_ptr_q][k] <= bus.in_data_i[k];
      end
    end
  end

  always_comb begin
    head_valid = ~empty;
    head_mask  = empty ? '0 : mask_mem[rd_ptr_q];
    for (int k = 0; k < NUM_LANES; k++) begin
      head_data[k] = data_mem[rd_ptr_q][k];
    end
`ifdef OPBUF_BYPASS_EN
    if (bypass_show) begin
      head_valid = 1'b1;
      head_mask  = bus.in_mask_i;
      for (int k = 0; k < NUM_LANES; k++) begin
        head_data[k] = bus.in_data_i[k];
      end
    end
`endif
  end

  assign bus.out_valid_o = head_valid;
  assign bus.out_mask_o  = head_mask;
  assign count_o         = count_q;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign bus.out_data_o[gi] = head_mask[gi] ? head_data[gi] : '0;
    end
  endgenerate

endmodule
